fp_32_to_16_pipe: RTL and testbench

Elastic two-stage pipeline that converts IEEE-754 binary32 results back to binary16 with round-to-nearest-even. It sits directly downstream of the fp32 arithmetic that consumes fp16-to-fp32 converted operands and returns accumulated values to fp16 storage. Each output carries per-result exception flags, and sticky status flags accumulate until software clears them.

---
 rtl/fp_32_to_16_pipe_if.sv | 24 ++
 rtl/fp_32_to_16_pipe.sv | 169 ++++++++++++++++
 tb/tb_fp_32_to_16_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_32_to_16_pipe_if.sv
// Stream bundle for the binary32 -> binary16 converter: upstream word
// handshake plus downstream result handshake with per-result flags.
`timescale 1ns/1ps
interface fp_32_to_16_pipe_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_fp32_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] result_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;

  modport master (
    output valid_i, operand_fp32_i, ready_i,
    input  ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
  );

  modport slave (
    input  valid_i, operand_fp32_i, ready_i,
    output ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
  );
endinterface

// File: rtl/fp_32_to_16_pipe.sv
// Elastic two-stage binary32 -> binary16 converter with round-to-nearest-even,
// per-result exception flags and software-clearable sticky flags.
`timescale 1ns/1ps
module fp_32_to_16_pipe (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fp_32_to_16_pipe_if.slave     bus,
  input  logic                  clear_flags_i,
  output logic                  sticky_overflow_o,
  output logic                  sticky_underflow_o,
  output logic                  sticky_inexact_o
);

  typedef enum logic [1:0] {CLS_ZERO, CLS_NAN, CLS_INF, CLS_FINITE} cls_t;

  logic               s1_valid;
  logic               s1_sign;
  cls_t               s1_cls;
  logic signed [9:0]  s1_e16;
  logic [23:0]        s1_sig;
  logic [3:0]         s1_shift;
  logic               s1_far;

  logic s2_can_load;
  logic in_fire;
  logic out_fire;

  assign s2_can_load = !bus.valid_o || bus.ready_i;
  assign bus.ready_o = !s1_valid || s2_can_load;
  assign in_fire     = bus.valid_i && bus.ready_o;
  assign out_fire    = bus.valid_o && bus.ready_i;

  logic [7:0]        in_exp;
  logic [22:0]       in_mant;
  logic signed [9:0] in_e16;
  logic signed [9:0] in_neg;
  cls_t              in_cls;

  assign in_exp  = bus.operand_fp32_i[30:23];
  assign in_mant = bus.operand_fp32_i[22:0];
  assign in_e16  = $signed({2'b00, in_exp}) - 10'sd112;
  // For tiny values the shift is 14 - e16; store it relative to 14 so it fits 4 bits.
  assign in_neg  = -in_e16;

  always_comb begin
    in_cls = CLS_FINITE;
    if (in_exp == 8'hFF)      in_cls = (|in_mant) ? CLS_NAN : CLS_INF;
    else if (in_exp == 8'h00) in_cls = CLS_ZERO;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_e16   <= '0;
      s1_sig   <= '0;
      s1_shift <= '0;
      s1_far   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_sign  <= bus.operand_fp32_i[31];
      s1_cls   <= in_cls;
      s1_e16   <= in_e16;
      s1_sig   <= {in_exp != 8'h00, in_mant};
      s1_shift <= in_neg[3:0];
      s1_far   <= (in_neg >= 10'sd12);
    end else if (s2_can_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Bits 35:26 hold the kept mantissa, bit 25 the guard, the rest feed sticky.
  logic [35:0] tiny_vec;
  assign tiny_vec = {s1_sig, 12'd0} >> s1_shift;

  logic [4:0]  exp5;
  logic [9:0]  m10;
  logic        guard_bit;
  logic        sticky_bit;
  logic [14:0] rounded;
  logic [15:0] res_d;
  logic        ovf_d;
  logic        unf_d;
  logic        inx_d;

  always_comb begin
    exp5       = '0;
    m10        = '0;
    guard_bit  = 1'b0;
    sticky_bit = 1'b0;
    rounded    = '0;
    res_d      = {s1_sign, 15'h0000};
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    inx_d      = 1'b0;
    case (s1_cls)
      CLS_NAN: res_d = {s1_sign, 5'h1F, 10'h200};
      CLS_INF: res_d = {s1_sign, 5'h1F, 10'h000};
      CLS_ZERO: begin
        inx_d = |s1_sig;
        unf_d = |s1_sig;
      end
      default: begin
        if (s1_e16 >= 10'sd31) begin
          res_d = {s1_sign, 5'h1F, 10'h000};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          if (s1_e16 >= 10'sd1) begin
            exp5       = s1_e16[4:0];
            m10        = s1_sig[22:13];
            guard_bit  = s1_sig[12];
            sticky_bit = |s1_sig[11:0];
          end else if (s1_far) begin
            sticky_bit = 1'b1;
          end else begin
            m10        = tiny_vec[35:26];
            guard_bit  = tiny_vec[25];
            sticky_bit = |tiny_vec[24:0];
          end
          // Single 15-bit add lets a mantissa carry ripple into the exponent.
          rounded = {exp5, m10} + {14'd0, guard_bit & (sticky_bit | m10[0])};
          inx_d   = guard_bit | sticky_bit;
          unf_d   = (s1_e16 <= 10'sd0) & inx_d;
          if (rounded[14:10] == 5'h1F) begin
            res_d = {s1_sign, 5'h1F, 10'h000};
            ovf_d = 1'b1;
            inx_d = 1'b1;
          end else begin
            res_d = {s1_sign, rounded};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.valid_o     <= 1'b0;
      bus.result_o    <= '0;
      bus.overflow_o  <= 1'b0;
      bus.underflow_o <= 1'b0;
      bus.inexact_o   <= 1'b0;
    end else if (s2_can_load) begin
      bus.valid_o <= s1_valid;
      if (s1_valid) begin
        bus.result_o    <= res_d;
        bus.overflow_o  <= ovf_d;
        bus.underflow_o <= unf_d;
        bus.inexact_o   <= inx_d;
      end
    end
  end

  // A flag being set by a consumed result wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_overflow_o  <= 1'b0;
      sticky_underflow_o <= 1'b0;
      sticky_inexact_o   <= 1'b0;
    end else begin
      sticky_overflow_o  <= (sticky_overflow_o  & ~clear_flags_i) | (out_fire & bus.overflow_o);
      sticky_underflow_o <= (sticky_underflow_o & ~clear_flags_i) | (out_fire & bus.underflow_o);
      sticky_inexact_o   <= (sticky_inexact_o   & ~clear_flags_i) | (out_fire & bus.inexact_o);
    end
  end

endmodule

// File: tb/tb_fp_32_to_16_pipe.sv
// Scoreboard bench for fp_32_to_16_pipe: stimulus pushes reference results,
// a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_fp_32_to_16_pipe;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clear_flags_i;
  logic sticky_overflow_o;
  logic sticky_underflow_o;
  logic sticky_inexact_o;

  fp_32_to_16_pipe_if bus ();

  fp_32_to_16_pipe dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .bus                (bus),
    .clear_flags_i      (clear_flags_i),
    .sticky_overflow_o  (sticky_overflow_o),
    .sticky_underflow_o (sticky_underflow_o),
    .sticky_inexact_o   (sticky_inexact_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int out_count = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp_word;
  logic [18:0] held;
  logic m_sovf = 1'b0, m_sunf = 1'b0, m_sinx = 1'b0;
  logic prev_valid = 1'b0, prev_fire = 1'b0, prev_stall = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Exact-value reference: the input is sig * 2^(E-23); pick the binary16
  // quantum for that magnitude, divide, round half to even, then encode.
  function automatic logic [18:0] ref_model(input logic [31:0] w);
    logic s;
    int e, big_e, q, k, be;
    longint sig, n, rem, half;
    bit inx, tiny;
    logic [14:0] mag;
    s = w[31];
    e = int'(w[30:23]);
    if (e == 255) return (w[22:0] != 0) ? {s, 15'h7E00, 3'b000} : {s, 15'h7C00, 3'b000};
    if (e == 0) begin
      inx = (w[22:0] != 0);
      return {s, 15'h0000, 1'b0, inx, inx};
    end
    big_e = e - 127;
    if (big_e >= 16) return {s, 15'h7C00, 3'b101};
    sig = longint'({1'b1, w[22:0]});
    q = ((big_e < -14) ? -14 : big_e) - 10;
    k = q - big_e + 23;
    if (k > 25) begin
      n = 0;
      inx = 1'b1;
    end else begin
      n = sig >> k;
      rem = sig - (n << k);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && n[0])) n = n + 1;
      inx = (rem != 0);
    end
    tiny = (big_e < -14);
    if (n >= 2048) begin
      n = n / 2;
      q = q + 1;
    end
    if (n < 1024) begin
      mag = 15'(n);
    end else begin
      be = q + 25;
      if (be >= 31) return {s, 15'h7C00, 3'b101};
      mag = {be[4:0], n[9:0]};
    end
    return {s, mag, 1'b0, tiny && inx, inx};
  endfunction

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 3) w[30:23] = 8'($urandom_range(97, 145));
    else if (sel <= 5) begin
      w[30:23] = 8'($urandom_range(100, 143));
      w[11:0] = 12'h000;
    end else if (sel == 6) w[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
    else if (sel == 7) w[30:0] = ($urandom_range(0, 1) == 0) ? 31'h0 : {8'hFF, 23'h0};
    return w;
  endfunction

  // Monitor and scoreboard: all sampling on the falling edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      m_sovf = 1'b0;
      m_sunf = 1'b0;
      m_sinx = 1'b0;
      prev_valid = 1'b0;
      prev_fire = 1'b0;
      prev_stall = 1'b0;
    end else begin
      logic in_hs, out_hs;
      logic [2:0] set_flags;
      checkOutput("sticky_overflow", {31'd0, sticky_overflow_o}, {31'd0, m_sovf});
      checkOutput("sticky_underflow", {31'd0, sticky_underflow_o}, {31'd0, m_sunf});
      checkOutput("sticky_inexact", {31'd0, sticky_inexact_o}, {31'd0, m_sinx});
      if (prev_stall && bus.valid_o)
        checkOutput("stall_hold", {13'd0, bus.result_o, bus.overflow_o, bus.underflow_o, bus.inexact_o},
                    {13'd0, held});
      if (prev_valid && !prev_fire)
        checkOutput("valid_hold", {31'd0, bus.valid_o}, 32'd1);
      in_hs = bus.valid_i && bus.ready_o;
      out_hs = bus.valid_o && bus.ready_i;
      if (in_hs) exp_q.push_back(ref_model(bus.operand_fp32_i));
      set_flags = 3'b000;
      if (out_hs) begin
        out_count++;
        if (exp_q.size() == 0) reportFail("unexpected_output");
        else begin
          exp_word = exp_q.pop_front();
          checkOutput("result", {16'd0, bus.result_o}, {16'd0, exp_word[18:3]});
          checkOutput("flags_ovf_unf_inx", {29'd0, bus.overflow_o, bus.underflow_o, bus.inexact_o},
                      {29'd0, exp_word[2:0]});
          set_flags = exp_word[2:0];
        end
      end
      m_sovf = (m_sovf & !clear_flags_i) | set_flags[2];
      m_sunf = (m_sunf & !clear_flags_i) | set_flags[1];
      m_sinx = (m_sinx & !clear_flags_i) | set_flags[0];
      prev_valid = bus.valid_o;
      prev_fire = out_hs;
      prev_stall = bus.valid_o && !bus.ready_i;
      held = {bus.result_o, bus.overflow_o, bus.underflow_o, bus.inexact_o};
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rand_ready) bus.ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic setReady(input logic v);
    rand_ready = 1'b0;
    @(posedge clk_i);
    #2;
    bus.ready_i = v;
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    bus.valid_i = 1'b1;
    bus.operand_fp32_i = word;
    while (!done) begin
      @(negedge clk_i);
      done = bus.ready_o;
      @(posedge clk_i);
      #1;
      waited++;
      if (!done && waited > 200) begin
        reportFail("input_accept_timeout");
        done = 1'b1;
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || bus.valid_o) && waited < 1000) begin
      @(posedge clk_i);
      #1;
      waited++;
    end
    if (waited >= 1000) reportFail("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [31:0] DIRECTED [13] = '{
    32'h3F800000, 32'h477FE000, 32'h477FF000, 32'hC0000000, 32'h3F801000,
    32'h3F803000, 32'h33800000, 32'h33000000, 32'h387FE000, 32'h00000001,
    32'h7FC00001, 32'hFF800000, 32'h80000000
  };

  initial begin
    logic [31:0] bp_words [3];
    int accepted, count_before;
    bit hs;
    rst_ni = 1'b0;
    clear_flags_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.operand_fp32_i = '0;
    bus.ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_valid_o", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("reset_result_o", {16'd0, bus.result_o}, 32'd0);
    checkOutput("reset_flags", {29'd0, bus.overflow_o, bus.underflow_o, bus.inexact_o}, 32'd0);
    checkOutput("reset_sticky", {29'd0, sticky_overflow_o, sticky_underflow_o, sticky_inexact_o}, 32'd0);
    rst_ni = 1'b1;
    checkOutput("ready_after_reset", {31'd0, bus.ready_o}, 32'd1);
    bus.ready_i = 1'b1;

    // Two-cycle latency from an idle pipeline.
    applyStimulus(32'h3F800000);
    checkOutput("latency_n1_valid", {31'd0, bus.valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("latency_n2_valid", {31'd0, bus.valid_o}, 32'd1);
    checkOutput("latency_n2_result", {16'd0, bus.result_o}, 32'h3C00);
    waitDrain();

    foreach (DIRECTED[i]) applyStimulus(DIRECTED[i]);
    waitDrain();

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      clear_flags_i = ($urandom_range(0, 15) == 0);
      applyStimulus(randWord());
      clear_flags_i = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end
    setReady(1'b1);
    waitDrain();

    // Backpressure: 3 words offered into a stalled output.
    setReady(1'b0);
    bp_words[0] = 32'h3F800000;
    bp_words[1] = 32'h40490FDB;
    bp_words[2] = 32'hC2C80000;
    accepted = 0;
    bus.valid_i = 1'b1;
    bus.operand_fp32_i = bp_words[0];
    for (int c = 0; c < 8; c++) begin
      if (c == 5) bus.ready_i = 1'b1;
      @(negedge clk_i);
      hs = bus.valid_i && bus.ready_o;
      if (c == 4) begin
        checkOutput("bp_accepts", accepted, 32'd2);
        checkOutput("bp_ready_low", {31'd0, bus.ready_o}, 32'd0);
      end
      if (c >= 5) checkOutput("bp_no_gap", {31'd0, bus.valid_o}, 32'd1);
      @(posedge clk_i);
      #1;
      if (hs) begin
        accepted++;
        if (accepted < 3) bus.operand_fp32_i = bp_words[accepted];
        else bus.valid_i = 1'b0;
      end
    end
    waitDrain();

    // Sticky flags: overflow sets, then clear coincides with an inexact result.
    applyStimulus(32'h477FF000);
    waitDrain();
    checkOutput("sticky_ovf_set", {31'd0, sticky_overflow_o}, 32'd1);
    applyStimulus(32'h3F801000);
    @(posedge clk_i);
    #1;
    clear_flags_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_flags_i = 1'b0;
    checkOutput("clear_vs_set_inexact", {31'd0, sticky_inexact_o}, 32'd1);
    checkOutput("clear_vs_set_overflow", {31'd0, sticky_overflow_o}, 32'd0);
    checkOutput("clear_vs_set_underflow", {31'd0, sticky_underflow_o}, 32'd0);
    waitDrain();

    // Reset with two words in flight must discard both.
    setReady(1'b0);
    applyStimulus(32'h3F800000);
    applyStimulus(32'h40000000);
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_valid_o", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("midreset_result_o", {16'd0, bus.result_o}, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    checkOutput("midreset_ready_o", {31'd0, bus.ready_o}, 32'd1);
    count_before = out_count;
    bus.ready_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    checkOutput("midreset_no_output", out_count - count_before, 32'd0);
    checkOutput("midreset_valid_idle", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
